// File: rtl/iso14443_2a_pkg.sv
// rtl/iso14443_2a_pkg.sv - shared ISO/IEC 14443-2 type A timing constants and scheduler state type
package iso14443_2a_pkg;

  localparam int BIT_PERIOD_TICKS = 128;
  localparam int FDT_OFFSET_LAST1 = 84;
  localparam int FDT_OFFSET_LAST0 = 20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TIMING,
    S_WAIT_GRID,
    S_RELEASED
  } fdt_state_e;

endpackage

// File: rtl/tx_interface.sv
// rtl/tx_interface.sv - bit-serial link between serialiser, fdt scheduler and tx
interface tx_interface;
  logic data;
  logic data_valid;
  logic last_bit_in_byte;
  logic req;

  modport in_bit (
    input  data,
    input  data_valid,
    input  last_bit_in_byte,
    output req
  );

  modport out_bit (
    output data,
    output data_valid,
    output last_bit_in_byte,
    input  req
  );
endinterface

// File: rtl/fdt_grid_counter.sv
// rtl/fdt_grid_counter.sv - phase/period counters since last pcd pause and fdt grid-point compare
module fdt_grid_counter
  import iso14443_2a_pkg::*;
#(
  parameter int FDT_N_MIN  = 9,
  parameter int TX_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_rise_i,
  input  logic hold_i,
  input  logic last1_i,
  output logic grid_o,
  output logic late_o
);

  // The counters read (t - 1) in tick t after the pause tick, and the grid tick sits one
  // tick before the release tick, so the compare target is offset - latency - 2. A negative
  // target borrows one bit period from the period count.
  localparam int TGT1 = FDT_OFFSET_LAST1 - TX_LATENCY - 2;
  localparam int TGT0 = FDT_OFFSET_LAST0 - TX_LATENCY - 2;
  localparam logic [6:0] PH1  = 7'((TGT1 + BIT_PERIOD_TICKS) % BIT_PERIOD_TICKS);
  localparam logic [6:0] PH0  = 7'((TGT0 + BIT_PERIOD_TICKS) % BIT_PERIOD_TICKS);
  localparam logic [4:0] MIN1 = 5'(FDT_N_MIN - ((TGT1 < 0) ? 1 : 0));
  localparam logic [4:0] MIN0 = 5'(FDT_N_MIN - ((TGT0 < 0) ? 1 : 0));

  logic [6:0] phase_q, phase_d;
  logic [3:0] periods_q, periods_d;
  logic [6:0] tgt_phase;
  logic [4:0] min_per;

  // Next-state: free-running phase, saturating period count, cleared by a pause unless held
  always_comb begin
    phase_d   = phase_q + 7'd1;
    periods_d = periods_q;
    if (phase_q == 7'd127 && periods_q != 4'd15) begin
      periods_d = periods_q + 4'd1;
    end
    if (pause_rise_i && !hold_i) begin
      phase_d   = '0;
      periods_d = '0;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= '0;
      periods_q <= '0;
    end else begin
      phase_q   <= phase_d;
      periods_q <= periods_d;
    end
  end

  assign tgt_phase = last1_i ? PH1 : PH0;
  assign min_per   = last1_i ? MIN1 : MIN0;
  assign grid_o    = (phase_q == tgt_phase) && ({1'b0, periods_q} >= min_per);
  assign late_o    = ({1'b0, periods_q} > min_per);

endmodule

// File: rtl/tx_fdt_scheduler.sv
// rtl/tx_fdt_scheduler.sv - holds tx data_valid until the fdt grid point; TX_FDT_TIMEOUT_EN adds wait timeout
module tx_fdt_scheduler #(
  parameter int FDT_N_MIN  = 9,
  parameter int TX_LATENCY = 2
`ifdef TX_FDT_TIMEOUT_EN
  , parameter int TIMEOUT_PERIODS = 64
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pause_rise,
  input  logic         rx_eof,
  input  logic         rx_last_bit,
  tx_interface.in_bit  in_iface,
  tx_interface.out_bit out_iface,
  output logic         busy,
  output logic         fdt_late
`ifdef TX_FDT_TIMEOUT_EN
  , output logic       fdt_timeout
`endif
);
  import iso14443_2a_pkg::*;

  fdt_state_e state_q;
  logic       last1_q;
  logic       fdt_late_q;
  logic       grid;
  logic       late;
`ifdef TX_FDT_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        fdt_timeout_q;
`endif

  fdt_grid_counter #(
    .FDT_N_MIN  (FDT_N_MIN),
    .TX_LATENCY (TX_LATENCY)
  ) u_grid (
    .clk          (clk),
    .rst_n        (rst_n),
    .pause_rise_i (pause_rise),
    .hold_i       (state_q == S_RELEASED),
    .last1_i      (last1_q),
    .grid_o       (grid),
    .late_o       (late)
  );

  // Scheduler FSM; a pause always takes priority over rx_eof and restarts timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last1_q    <= 1'b0;
      fdt_late_q <= 1'b0;
`ifdef TX_FDT_TIMEOUT_EN
      to_cnt_q      <= '0;
      fdt_timeout_q <= 1'b0;
`endif
    end else begin
      fdt_late_q <= 1'b0;
`ifdef TX_FDT_TIMEOUT_EN
      fdt_timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (rx_eof && !pause_rise) begin
            state_q <= S_TIMING;
            last1_q <= rx_last_bit;
          end
        end
        S_TIMING: begin
          if (pause_rise) begin
            state_q <= S_IDLE;
          end else if (grid) begin
            if (in_iface.data_valid) begin
              state_q    <= S_RELEASED;
              fdt_late_q <= late;
            end else begin
              state_q <= S_WAIT_GRID;
`ifdef TX_FDT_TIMEOUT_EN
              to_cnt_q <= '0;
`endif
            end
          end
        end
        S_WAIT_GRID: begin
          if (pause_rise) begin
            state_q <= S_IDLE;
          end else if (grid) begin
            if (in_iface.data_valid) begin
              state_q    <= S_RELEASED;
              fdt_late_q <= late;
            end
`ifdef TX_FDT_TIMEOUT_EN
            else if (to_cnt_q == 16'(TIMEOUT_PERIODS - 1)) begin
              state_q       <= S_IDLE;
              fdt_timeout_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 16'd1;
            end
`endif
          end
        end
        S_RELEASED: begin
          if (!in_iface.data_valid) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_iface.data             = in_iface.data;
  assign out_iface.last_bit_in_byte = in_iface.last_bit_in_byte;
  assign out_iface.data_valid       = in_iface.data_valid & (state_q == S_RELEASED);
  assign in_iface.req               = out_iface.req;
  assign busy                       = (state_q != S_IDLE);
  assign fdt_late                   = fdt_late_q;
`ifdef TX_FDT_TIMEOUT_EN
  assign fdt_timeout                = fdt_timeout_q;
`endif

endmodule

// File: tb/tb_tx_fdt_scheduler.sv
// tb/tb_tx_fdt_scheduler.sv - scoreboard bench for tx_fdt_scheduler release timing and passthrough
module tb_tx_fdt_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause_rise = 1'b0;
  logic rx_eof = 1'b0;
  logic rx_last_bit = 1'b0;
  logic busy;
  logic fdt_late;
`ifdef TX_FDT_TIMEOUT_EN
  logic fdt_timeout;
`endif

  tx_interface ser_if ();
  tx_interface tx_if ();

  tx_fdt_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pause_rise  (pause_rise),
    .rx_eof      (rx_eof),
    .rx_last_bit (rx_last_bit),
    .in_iface    (ser_if),
    .out_iface   (tx_if),
    .busy        (busy),
    .fdt_late    (fdt_late)
`ifdef TX_FDT_TIMEOUT_EN
    , .fdt_timeout (fdt_timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int t0 = 0;
  int rise_cnt = 0;
  int late_cnt = 0;
  int late_tick = -1;
  int to_cnt = 0;
  int exp_q[$];
  int exp_to_q[$];
  logic dv_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) tick_cnt <= tick_cnt + 1;

  // Scoreboard side: every release edge pops the next expected release tick
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_if.data_valid && !dv_prev) begin
        rise_cnt++;
        check("rise_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("rise_tick", tick_cnt - t0, exp_q.pop_front());
      end
      if (fdt_late) begin
        late_cnt++;
        late_tick = tick_cnt - t0;
      end
`ifdef TX_FDT_TIMEOUT_EN
      if (fdt_timeout) begin
        to_cnt++;
        check("timeout_expected", 32'(exp_to_q.size() != 0), 1);
        if (exp_to_q.size() != 0) check("timeout_tick", tick_cnt - t0, exp_to_q.pop_front());
      end
`endif
    end
    dv_prev = tx_if.data_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_pause();
    pause_rise = 1'b1;
    step(1);
    pause_rise = 1'b0;
  endtask

  task automatic start_frame(input logic lb, input int eof_delay);
    t0 = tick_cnt;
    pulse_pause();
    step(eof_delay - 1);
    rx_eof = 1'b1;
    rx_last_bit = lb;
    step(1);
    rx_eof = 1'b0;
  endtask

  task automatic wait_until(input int rel);
    while (tick_cnt - t0 < rel) step(1);
  endtask

  task automatic wait_rise(input int target, input int budget);
    int n = 0;
    while (rise_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    check("rise_wait", rise_cnt, target);
  endtask

  task automatic end_frame();
    ser_if.data_valid = 1'b0;
    #1;
    check("dv_drop_same_tick", tx_if.data_valid, 0);
    check("busy_at_drop", busy, 1);
    step(1);
    check("idle_after_drop", busy, 0);
  endtask

  initial begin
    int saved;
    logic [15:0] frame;
    ser_if.data = 1'b0;
    ser_if.data_valid = 1'b1;
    ser_if.last_bit_in_byte = 1'b0;
    tx_if.req = 1'b0;

    step(3);
    check("rst_out_dv", tx_if.data_valid, 0);
    check("rst_req", ser_if.req, 0);
    check("rst_busy", busy, 0);
    check("rst_late", fdt_late, 0);
    rst_n = 1'b1;
    step(2);

    // last bit 1, data valid early, then 16-bit passthrough
    late_cnt = 0;
    exp_q.push_back(9 * 128 + 84 - 2);
    start_frame(1'b1, 3);
    wait_until(100);
    check("busy_timing", busy, 1);
    wait_rise(1, 3000);
    frame = 16'($urandom);
    for (int i = 0; i < 16; i++) begin
      ser_if.data = frame[i];
      ser_if.last_bit_in_byte = (i % 8 == 7);
      tx_if.req = ~tx_if.req;
      #1;
      check("req_mirror", ser_if.req, tx_if.req);
      check("data_pass", tx_if.data, frame[i]);
      check("lbib_pass", tx_if.last_bit_in_byte, 32'(i % 8 == 7));
      check("dv_in_frame", tx_if.data_valid, 1);
      step(1);
    end
    end_frame();
    check("late_none_1", late_cnt, 0);
    tx_if.req = 1'b0;
    step(5);

    // last bit 0, data valid early
    ser_if.data_valid = 1'b1;
    exp_q.push_back(9 * 128 + 20 - 2);
    start_frame(1'b0, 3);
    wait_rise(2, 3000);
    end_frame();
    check("late_none_2", late_cnt, 0);
    step(5);

    // data arrives after the first grid point: released one bit period later
    ser_if.data_valid = 1'b0;
    exp_q.push_back(10 * 128 + 84 - 2);
    start_frame(1'b1, 3);
    wait_until(1300);
    check("busy_wait_grid", busy, 1);
    ser_if.data_valid = 1'b1;
    wait_rise(3, 3000);
    end_frame();
    check("late_count_3", late_cnt, 1);
    check("late_tick_3", late_tick, 1362);
    step(5);

    // rx_eof arrives after n = FDT_N_MIN has passed: next grid point, flagged late
    late_cnt = 0;
    ser_if.data_valid = 1'b1;
    exp_q.push_back(10 * 128 + 84 - 2);
    start_frame(1'b1, 1300);
    wait_rise(4, 3000);
    end_frame();
    check("late_count_4", late_cnt, 1);
    check("late_tick_4", late_tick, 1362);
    step(5);

    // new pcd pause during timing aborts the response
    ser_if.data_valid = 1'b1;
    saved = rise_cnt;
    start_frame(1'b1, 3);
    wait_until(500);
    pulse_pause();
    check("idle_after_pause", busy, 0);
    wait_until(1400);
    check("no_release_after_pause", rise_cnt, saved);
    ser_if.data_valid = 1'b0;
    step(5);

    // reset while released drops everything at once
    ser_if.data_valid = 1'b1;
    exp_q.push_back(9 * 128 + 84 - 2);
    start_frame(1'b1, 3);
    wait_rise(5, 3000);
    step(3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_dv", tx_if.data_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_late", fdt_late, 0);
    step(2);
    ser_if.data_valid = 1'b0;
    rst_n = 1'b1;
    step(3);

`ifdef TX_FDT_TIMEOUT_EN
    // no data ever: timeout after 64 wait-grid points
    saved = rise_cnt;
    exp_to_q.push_back(9 * 128 + 84 - 2 + 64 * 128);
    start_frame(1'b1, 3);
    begin
      int n = 0;
      while (to_cnt < 1 && n < 12000) begin
        step(1);
        n++;
      end
    end
    step(3);
    check("timeout_count", to_cnt, 1);
    check("timeout_idle", busy, 0);
    check("timeout_no_rise", rise_cnt, saved);
`endif

    check("scoreboard_empty", exp_q.size() + exp_to_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_fdt_scheduler.md
# tx_fdt_scheduler

Sequences the PICC transmit path so every response frame starts on the ISO/IEC 14443-3 frame delay time (FDT) grid. It sits between the serialiser output and the `tx` block. It withholds `data_valid` from `tx` until the FDT release point after the last PCD pause. It then passes the frame through bit by bit until the serialiser drops `data_valid`.

## Interface
Parameters:
- `FDT_N_MIN`, default 9. Minimum n in FDT = n·128 + offset.
- `TX_LATENCY`, default 2. Ticks from `out_iface.data_valid` rising to the first SOC subcarrier edge on `lm_out`. Legal range 0..20.
- `TIMEOUT_PERIODS`, default 64. Bit periods spent in WAIT_GRID before giving up. Only present with `TX_FDT_TIMEOUT_EN`.

Ports:
- `clk`  in  1  13.56 MHz clock.
- `rst_n`  in  1  Asynchronous, active-low reset (synchronised deassertion).
- `pause_rise`  in  1  One-tick pulse at the rising edge of every PCD pause.
- `rx_eof`  in  1  One-tick pulse when the rx path detects end of PCD frame.
- `rx_last_bit`  in  1  Last data bit of the PCD frame. Valid with `rx_eof`.
- `in_iface`  tx_interface.in_bit  —  Serialiser side (`data`, `data_valid`, `last_bit_in_byte`, `req`).
- `out_iface`  tx_interface.out_bit  —  To `tx`.
- `busy`  out  1  State ≠ IDLE.
- `fdt_late`  out  1  One-tick pulse when release happens at n > `FDT_N_MIN`.
- `fdt_timeout`  out  1  One-tick pulse on timeout. Only present with `TX_FDT_TIMEOUT_EN`.

## Operation
- Passthrough: `out_iface.data`, `out_iface.last_bit_in_byte` = `in_iface` equivalents. `in_iface.req` = `out_iface.req`.
- Gating: `out_iface.data_valid` = `in_iface.data_valid` AND (state == RELEASED).
- Phase counter (7 bit) and period counter (4 bit, saturating at 15) both reset to 0 on `pause_rise` in any state except RELEASED.
  - Otherwise the phase counter increments each tick.
  - When phase wraps 127→0, the period counter increments.
- Offset: latched on `rx_eof`. It is 84 if `rx_last_bit` = 1, 20 if 0.
- Grid point: phase == offset − `TX_LATENCY` and periods ≥ `FDT_N_MIN`.

State machine:
- IDLE. On `rx_eof` go to TIMING and latch the offset.
- TIMING. On the first grid point:
  - if `in_iface.data_valid` is high, go to RELEASED;
  - else go to WAIT_GRID.
  - `pause_rise` here resets the counters and returns to IDLE (new PCD frame).
- WAIT_GRID. At each subsequent grid point (every 128 ticks), if `in_iface.data_valid` is high, go to RELEASED and pulse `fdt_late`. `pause_rise` returns to IDLE.
- RELEASED. `pause_rise` and `rx_eof` are ignored. When `in_iface.data_valid` is low, go to IDLE.
- If `rx_eof` arrives with periods already past `FDT_N_MIN`, the next grid point is used.
- `rx_eof` and `pause_rise` in the same tick: `pause_rise` wins.

## Timing
- Reset values: state IDLE; counters 0; `out_iface.data_valid`, `in_iface.req`, `busy`, `fdt_late`, `fdt_timeout` all 0.
- Release latency: `out_iface.data_valid` rises combinationally in the first tick state == RELEASED. That tick is grid point + 1.
  - Rise tick = n·128 + offset − `TX_LATENCY` ticks after the `pause_rise` tick (tick 0).
- Register the state transition on the grid point tick.
- Frame end: `out_iface.data_valid` follows `in_iface.data_valid` low in the same tick. The state returns to IDLE next tick.
- Reset mid-frame forces `out_iface.data_valid` low immediately (asynchronous).

## Configuration
- `TX_FDT_TIMEOUT_EN` defined:
  - A period counter runs in WAIT_GRID.
  - After `TIMEOUT_PERIODS` grid points without data, pulse `fdt_timeout` and go to IDLE.
- Not defined: WAIT_GRID waits indefinitely, and the `fdt_timeout` port is absent.

## Structure
- Shared package `iso14443_2a_pkg` holds:
  - `BIT_PERIOD_TICKS` = 128;
  - `FDT_OFFSET_LAST1` = 84;
  - `FDT_OFFSET_LAST0` = 20;
  - the scheduler state enum typedef.
- One sub-module, `fdt_grid_counter`: the phase/period counters, the reset on `pause_rise`, and the grid-point compare output.

## Test plan
- Last bit 1, data valid early, `pause_rise` at tick 0 → `out_iface.data_valid` rises at tick 1234 (9·128+84−2). `fdt_late` stays 0.
- Last bit 0, data valid early → rise at tick 1170.
- Last bit 1, `in_iface.data_valid` rises at tick 1300 → release at tick 1362. `fdt_late` pulses once.
- `pause_rise` at tick 500 while in TIMING → no release, state returns to IDLE, and `busy` = 0 next tick.
- 16-bit frame released, then serialiser drops valid → `in_iface.req` mirrors `out_iface.req` for all 16 bits, then IDLE.
- Reset asserted mid-RELEASED → all outputs 0 immediately. With `TX_FDT_TIMEOUT_EN`, no data for 64 grid points → one `fdt_timeout` pulse, then IDLE.
